// File: rtl/seq_det_counter.sv
// seq_det_counter: detects the ascending symbol run 1,2,...,LEN in a stream
// of SYM_W-bit symbols (one per enabled clock). A strict/relaxed mode input
// controls whether consecutive repeats of a symbol are tolerated. Each
// completed run produces a one-cycle registered pulse on ans and bumps an
// occurrence counter.
//
// Optional feature macro: SEQ_DET_SAT_EN
//   defined   -> cnt saturates at all-ones and ovf is a sticky overflow flag
//   undefined -> cnt wraps modulo 2^CNT_W and ovf is tied to 0
module seq_det_counter #(
    parameter int SYM_W = 2,
    parameter int LEN   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             strict,
    input  logic [SYM_W-1:0] num,
    input  logic             clr,
    output logic             ans,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic [SYM_W-1:0] stage
);

    // Widened copies so that stage+1 never wraps when compared with num.
    localparam logic [SYM_W:0]   LEN_X  = (SYM_W+1)'(LEN);
    localparam logic [SYM_W-1:0] LEN_S  = SYM_W'(LEN);
    localparam logic [SYM_W-1:0] LEN_M1 = SYM_W'(LEN - 1);
    localparam logic [SYM_W-1:0] ONE_S  = SYM_W'(1);

    logic [SYM_W-1:0] r_stage;
    logic             r_ans;
    logic [CNT_W-1:0] r_cnt;

    logic [SYM_W-1:0] w_stage_nxt;
    logic [SYM_W:0]   w_stage_x;
    logic [SYM_W:0]   w_num_x;
    logic             w_match;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_stage_x = {1'b0, r_stage};
    assign w_num_x   = {1'b0, num};

    // A run completes when the stage just below LEN sees the symbol LEN.
    // A repeated LEN at stage LEN is not a new completion.
    assign w_match = en && (r_stage == LEN_M1) && (num == LEN_S);

    // Next match stage: advance on the successor symbol, hold on a relaxed
    // repeat, otherwise restart at 1 (if num is 1) or fall back to 0.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_stage_nxt = r_stage;
        if (en) begin
            if ((w_stage_x < LEN_X) && (w_num_x == w_stage_x + (SYM_W+1)'(1))) begin
                w_stage_nxt = r_stage + ONE_S;
            end else if (!strict && (r_stage != '0) && (num == r_stage)) begin
                w_stage_nxt = r_stage;
            end else if (num == ONE_S) begin
                w_stage_nxt = ONE_S;
            end else begin
                w_stage_nxt = '0;
            end
        end
    end

    // Stage register and registered completion pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (reset) begin
            r_stage <= '0;
            r_ans   <= 1'b0;
        end else begin
            r_stage <= w_stage_nxt;
            r_ans   <= w_match;
        end
    end

`ifdef SEQ_DET_SAT_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // Counter next state: clear wins over increment (a match during clear
    // still counts); increments stop at all-ones and flag the lost match.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (clr) begin
            w_cnt_nxt = w_match ? CNT_W'(1) : '0;
            w_ovf_nxt = 1'b0;
        end else if (w_match) begin
            if (r_cnt == '1) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`else
    // Counter next state: clear wins over increment (a match during clear
    // still counts); increments wrap around.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = w_match ? CNT_W'(1) : '0;
        end else if (w_match) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign ovf = 1'b0;
`endif

    assign ans   = r_ans;
    assign cnt   = r_cnt;
    assign stage = r_stage;

endmodule
